io_bus_timeout_bridge: RTL and testbench

//  Sits directly downstream of the soft-CPU subsystem's 8-bit I/O master port
//  (io_address/io_read/io_write/io_wdata -> io_rdata/io_ack) and upstream of the peripheral I/O tree.

---
 rtl/io_bus_timeout_bridge.sv | 126 ++++++++++++
 tb/tb_io_bus_timeout_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_timeout_bridge.sv
// Bridge between the CPU I/O master port and the peripheral tree; completes unanswered accesses after a timeout.
// Optional registered timeout interrupt enabled by defining IO_TIMEOUT_IRQ_EN.
module io_bus_timeout_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [7:0]  DEFAULT_RDATA  = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] io_address,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [7:0]  io_wdata,
  output logic [7:0]  io_rdata,
  output logic        io_ack,
  output logic [19:0] slv_address,
  output logic        slv_read,
  output logic        slv_write,
  output logic [7:0]  slv_wdata,
  input  logic [7:0]  slv_rdata,
  input  logic        slv_ack,
  input  logic        err_clear,
  output logic        err_sticky,
  output logic [7:0]  err_count,
  output logic [19:0] err_address,
  output logic        timeout_irq
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_p1;
  logic             rd_p1;
  logic             accept, ack_hit, to_hit, proto_err;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    proto_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_read || io_write) begin
          accept    = 1'b1;
          proto_err = io_read && io_write;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        proto_err = io_read || io_write;
        // A slave ack landing on the final wait cycle still wins over the timeout.
        if (slv_ack) begin
          ack_hit = 1'b1;
          state_d = IDLE;
        end else if (cnt_p1 == CNT_LAST) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request stage: forward strobes, count wait cycles, complete the access
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_p1      <= '0;
      rd_p1       <= 1'b0;
      slv_address <= '0;
      slv_wdata   <= '0;
      slv_read    <= 1'b0;
      slv_write   <= 1'b0;
      io_ack      <= 1'b0;
      io_rdata    <= '0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      err_address <= '0;
    end else begin
      state_q   <= state_d;
      slv_read  <= accept && io_read && !io_write;
      slv_write <= accept && io_write;
      io_ack    <= ack_hit || to_hit;
      if (accept) begin
        slv_address <= io_address;
        rd_p1       <= io_read && !io_write;
        cnt_p1      <= '0;
      end else if (state_q == WAIT) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
      if (accept && io_write) slv_wdata <= io_wdata;
      if (ack_hit) io_rdata <= rd_p1 ? slv_rdata : 8'h00;
      else if (to_hit) io_rdata <= rd_p1 ? DEFAULT_RDATA : 8'h00;
      if (to_hit) err_address <= slv_address;
      if (err_clear) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end else begin
        if (to_hit || proto_err) err_sticky <= 1'b1;
        if (to_hit && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

`ifdef IO_TIMEOUT_IRQ_EN
  logic to_done_p2;

  // Irq stage: level rises the cycle after the timed-out io_ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_done_p2  <= 1'b0;
      timeout_irq <= 1'b0;
    end else begin
      to_done_p2 <= to_hit && !err_clear;
      if (err_clear) timeout_irq <= 1'b0;
      else if (to_done_p2) timeout_irq <= 1'b1;
    end
  end
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_timeout_bridge.sv
// Scoreboard bench for io_bus_timeout_bridge: randomized accesses against a transaction-level model.
module tb_io_bus_timeout_bridge;
  localparam int TO = 16;
  localparam logic [7:0] DEF = 8'hFF;
`ifdef IO_TIMEOUT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] io_address = '0;
  logic        io_read = 1'b0, io_write = 1'b0;
  logic [7:0]  io_wdata = '0;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic [19:0] slv_address;
  logic        slv_read, slv_write;
  logic [7:0]  slv_wdata;
  logic [7:0]  slv_rdata = '0;
  logic        slv_ack = 1'b0;
  logic        err_clear = 1'b0;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [19:0] err_address;
  logic        timeout_irq;

  io_bus_timeout_bridge #(.TIMEOUT_CYCLES(TO), .DEFAULT_RDATA(DEF)) dut (
    .clock(clock), .reset_n(reset_n), .io_address(io_address), .io_read(io_read),
    .io_write(io_write), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
    .slv_address(slv_address), .slv_read(slv_read), .slv_write(slv_write),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .err_clear(err_clear), .err_sticky(err_sticky), .err_count(err_count),
    .err_address(err_address), .timeout_irq(timeout_irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic rd; logic wr; logic [19:0] addr; logic [7:0] wdata; } fwd_t;
  typedef struct { int cyc; logic [7:0] rdata; logic [7:0] cnt; logic sticky; logic [19:0] eaddr; logic irq; } ack_t;
  fwd_t fq[$];
  ack_t aq[$];
  fwd_t f_mon;
  ack_t a_mon;

  int errors = 0;
  int checks = 0;

  // Transaction-level model of the error state
  int          m_cnt = 0;
  bit          m_sticky = 0;
  logic [19:0] m_addr = '0;
  bit          m_irq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or an ack
  always @(negedge clock) begin
    if (reset_n) begin
      if (slv_read || slv_write) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fwd_unexpected: got slv_read=%0b slv_write=%0b at cycle %0d required none", slv_read, slv_write, cyc);
        end else begin
          f_mon = fq.pop_front();
          check("fwd_cycle", cyc, f_mon.cyc);
          check("fwd_read", slv_read, f_mon.rd);
          check("fwd_write", slv_write, f_mon.wr);
          check("fwd_addr", slv_address, f_mon.addr);
          if (f_mon.wr) check("fwd_wdata", slv_wdata, f_mon.wdata);
        end
      end else if (fq.size() != 0 && fq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL fwd_missing: got no strobe by cycle %0d required one at %0d", cyc, fq[0].cyc);
        void'(fq.pop_front());
      end
      if (io_ack) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: got io_ack=1 at cycle %0d required none", cyc);
        end else begin
          a_mon = aq.pop_front();
          check("ack_cycle", cyc, a_mon.cyc);
          check("ack_rdata", io_rdata, a_mon.rdata);
          check("ack_err_count", err_count, a_mon.cnt);
          check("ack_err_sticky", err_sticky, a_mon.sticky);
          check("ack_err_address", err_address, a_mon.eaddr);
          check("ack_timeout_irq", timeout_irq, a_mon.irq);
        end
      end else if (aq.size() != 0 && aq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL ack_missing: got no io_ack by cycle %0d required one at %0d", cyc, aq[0].cyc);
        void'(aq.pop_front());
      end
    end
  end

  // op: 0 read, 1 write, 2 read+write; k: slave latency, negative or >= TO means no slave answer
  task automatic xact(input int op, input logic [19:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                      input int k, input bit drop, input bit late, input int gap, input bit clr);
    int T, A;
    bit isrd, to;
    fwd_t f;
    ack_t a;
    T = cyc;
    io_address = addr; io_wdata = wd;
    io_read = (op != 1); io_write = (op != 0); err_clear = clr;
    f.cyc = T + 1; f.rd = (op == 0); f.wr = (op != 0); f.addr = addr; f.wdata = wd;
    fq.push_back(f);
    isrd = (op == 0);
    to = (k < 0) || (k >= TO);
    if (clr) begin m_cnt = 0; m_sticky = 0; m_irq = 0; end
    else if (op == 2) m_sticky = 1;
    if (drop) m_sticky = 1;
    A = to ? T + 1 + TO : T + 2 + k;
    a.irq = IRQ_EN && m_irq;
    if (to) begin
      if (m_cnt < 255) m_cnt++;
      m_sticky = 1;
      m_addr = addr;
    end
    a.cyc = A;
    a.rdata = to ? (isrd ? DEF : 8'h00) : (isrd ? rd : 8'h00);
    a.cnt = m_cnt[7:0]; a.sticky = m_sticky; a.eaddr = m_addr;
    aq.push_back(a);
    if (to) m_irq = 1;
    goto(T + 1);
    io_read = 0; io_write = 0; err_clear = 0;
    io_address = 20'($urandom); io_wdata = 8'($urandom);
    if (drop) begin
      goto(T + 2);
      io_read = $urandom_range(0, 1) == 1; io_write = !io_read;
      io_address = 20'($urandom);
      goto(T + 3);
      io_read = 0; io_write = 0;
    end
    if (!to) begin
      goto(T + 1 + k);
      slv_ack = 1; slv_rdata = rd;
      goto(T + 2 + k);
      slv_ack = 0; slv_rdata = 8'($urandom);
    end else begin
      goto(A);
      if (late) begin
        slv_ack = 1; slv_rdata = 8'($urandom);
        goto(A + 1);
        slv_ack = 0;
      end
`ifdef IO_TIMEOUT_IRQ_EN
      goto(A + 1);
      check("irq_after_timeout", timeout_irq, 1'b1);
`endif
    end
    goto(A + gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_io_ack"}, io_ack, 0);
    check({tag, "_io_rdata"}, io_rdata, 0);
    check({tag, "_slv_read"}, slv_read, 0);
    check({tag, "_slv_write"}, slv_write, 0);
    check({tag, "_slv_address"}, slv_address, 0);
    check({tag, "_slv_wdata"}, slv_wdata, 0);
    check({tag, "_err_sticky"}, err_sticky, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_err_address"}, err_address, 0);
    check({tag, "_timeout_irq"}, timeout_irq, 0);
  endtask

  task automatic do_clear();
    err_clear = 1;
    goto(cyc + 1);
    err_clear = 0;
    m_cnt = 0; m_sticky = 0; m_irq = 0;
    check("clear_err_count", err_count, 0);
    check("clear_err_sticky", err_sticky, 0);
    check("clear_timeout_irq", timeout_irq, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t required completion", $time);
    $fatal(1);
  end

  initial begin
    int op, r, k, T;
    bit drop, late, clr;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1;
    goto(cyc + 2);

    xact(0, 20'h00123, 8'h00, 8'h5A, 3, 0, 0, 1, 0);
    xact(1, 20'hFFFFF, 8'hC3, 8'h00, 0, 0, 0, 1, 0);
    xact(0, 20'h04000, 8'h00, 8'h00, -1, 0, 1, 1, 0);
    xact(0, 20'h00777, 8'h00, 8'h3C, TO - 1, 0, 0, 1, 0);
    xact(1, 20'h00888, 8'h11, 8'h00, -1, 0, 0, 1, 0);
    do_clear();
    xact(0, 20'h00999, 8'h00, 8'hA5, 5, 1, 0, 1, 0);
    xact(2, 20'h0ABCD, 8'h66, 8'h00, 2, 0, 0, 1, 1);
    xact(2, 20'h0ABCE, 8'h67, 8'h00, 0, 0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      op = (op < 5) ? 0 : (op < 9) ? 1 : 2;
      r = $urandom_range(0, 9);
      k = (r <= 5) ? $urandom_range(0, 5) : (r == 6) ? TO - 1 : (r == 8) ? $urandom_range(2, TO - 2) : -1;
      drop = ($urandom_range(0, 4) == 0) && (k < 0 || k >= 2);
      late = (k < 0) && ($urandom_range(0, 1) == 1);
      clr = $urandom_range(0, 9) == 0;
      xact(op, 20'($urandom), 8'($urandom), 8'($urandom), k, drop, late, $urandom_range(0, 2), clr);
    end

    // Reset in the middle of a wait: access abandoned, no io_ack afterwards
    T = cyc;
    io_read = 1; io_address = 20'h0C0DE;
    fq.push_back('{T + 1, 1'b1, 1'b0, 20'h0C0DE, 8'h00});
    goto(T + 1);
    io_read = 0;
    goto(T + 4);
    reset_n = 0;
    #1;
    check_all_zero("midreset");
    m_cnt = 0; m_sticky = 0; m_irq = 0; m_addr = '0;
    goto(T + 6);
    reset_n = 1;
    goto(T + 6 + TO + 4);

    for (int i = 0; i < 300; i++)
      xact(i % 2, 20'($urandom), 8'($urandom), 8'h00, -1, 0, 1, 0, 0);
    goto(cyc + 1);
    check("saturated_count", err_count, 8'hFF);
    check("saturated_sticky", err_sticky, 1'b1);
    do_clear();

    goto(cyc + 4);
    check("fwd_queue_drained", fq.size(), 0);
    check("ack_queue_drained", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
